// File: rtl/instr_encoder_loader.sv
// RV32I subset encoder that streams instruction words into instruction memory.
// Optional ENC_RANGE_CHECK_EN enables immediate range/alignment checking.
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-2:0] instr_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = 4;
    localparam logic [ADDR_WIDTH-2:0] CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [ADDR_WIDTH-2:0] cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [31:0] enc_word;
    logic        bad_op;
    logic        bad_imm;

`ifdef ENC_RANGE_CHECK_EN
    logic i_ok, b_ok, j_ok, u_ok;
    assign i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign u_ok = ~(|in_imm[31:20]);
`else
    // Upper immediate bits only matter when range checking is built in.
    logic unused_imm;
    assign unused_imm = ^in_imm[31:21];
`endif

    always_comb begin
        enc_word = '0;
        bad_op   = 1'b0;
        bad_imm  = 1'b0;
        case (in_op)
            4'd0: enc_word = {7'b0, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            4'd1: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            4'd2: enc_word = {in_imm[11:0], in_rs1, 3'b100, in_rd, 7'b0000011};
            4'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b000,
                              in_imm[4:0], 7'b0100011};
            4'd4: enc_word = {in_imm[19:0], in_rd, 7'b0110111};
            4'd5: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                              in_imm[4:1], in_imm[11], 7'b1100011};
            4'd6: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b111,
                              in_imm[4:1], in_imm[11], 7'b1100011};
            4'd7: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            4'd8: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, 7'b1101111};
            default: bad_op = 1'b1;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        case (in_op)
            4'd1, 4'd2, 4'd3, 4'd7: bad_imm = ~i_ok;
            4'd4:                   bad_imm = ~u_ok;
            4'd5, 4'd6:             bad_imm = ~b_ok;
            4'd8:                   bad_imm = ~j_ok;
            default:                bad_imm = 1'b0;
        endcase
`endif
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        err_d   = err_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    last_d = in_last;
                    if (bad_op || bad_imm) begin
                        err_d = 1'b1;
                        if (!err_q) code_d = bad_op ? 2'b01 : 2'b10;
                        state_d = in_last ? S_DONE : S_LOAD;
                    end else begin
                        wdata_d = enc_word;
                        waddr_d = addr_q;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_STEP;
                cnt_d  = cnt_q + CNT_ONE;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (addr_q == LAST_ADDR) begin
                    // Memory full with more words pending: stop rather than wrap.
                    err_d = 1'b1;
                    if (!err_q) code_d = 2'b11;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        we_d   = (state_d == S_WRITE);
        rdy_d  = (state_d == S_LOAD);
        busy_d = (state_d == S_LOAD) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready    = rdy_q;
    assign imem_we     = we_q;
    assign imem_addr   = waddr_q;
    assign imem_wdata  = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign instr_count = cnt_q;

endmodule
